// File: rtl/sk9822_pkg.sv
// Shared constants, FSM state type and end-frame sizing for the SK9822/APA102 chain driver.
package sk9822_pkg;

   localparam logic [31:0] START_WORD = 32'h0000_0000;
   localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
   localparam logic [2:0]  HDR        = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      START_F,
      PIXEL,
      END_F
   } state_t;

   // One 32-bit end word covers 64 LEDs of data-propagation delay (half a clock each).
   function automatic int end_words(input int led_num);
      int w;
      w = (led_num + 63) / 64;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sk9822_sck_gen.sv
// SCK phase generator: CLK_DIV clk cycles per half-period, low phase first, idle-low when disabled.
module sk9822_sck_gen #(
   parameter int CLK_DIV = 14
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sk_ck_next,
   output logic fall_tick,
   output logic bit_end
);

   localparam int               DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             phase_hi;
   logic             phase_end;

   assign phase_end  = en && (div_cnt == DIV_LAST);
   assign sk_ck_next = en && (phase_end ? !phase_hi : phase_hi);
   assign fall_tick  = en && !phase_hi && (div_cnt == '0);
   assign bit_end    = phase_end && phase_hi;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         phase_hi <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         phase_hi <= 1'b0;
      end else if (phase_end) begin
         div_cnt  <= '0;
         phase_hi <= !phase_hi;
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/sk9822_chain_driver.sv
// SK9822/APA102 chain driver: one start frame, LED_NUM pixel words and a length-scaled end frame per start.
module sk9822_chain_driver
   import sk9822_pkg::*;
#(
   parameter int LED_NUM = 11,
   parameter int CLK_DIV = 14,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        bright,
   output logic [ADDR_W-1:0] pix_addr,
   input  logic [23:0]       pix_data,
   output logic              busy,
   output logic              done,
   output logic              sk_ck,
   output logic              sk_da
);

   localparam int                END_WORDS     = end_words(LED_NUM);
   localparam int                TOTAL_WORDS   = 1 + LED_NUM + END_WORDS;
   localparam int                WC_W          = $clog2(TOTAL_WORDS + 1);
   localparam logic [WC_W-1:0]   LAST_PIX_IDX  = WC_W'(LED_NUM);
   localparam logic [WC_W-1:0]   LAST_WORD_IDX = WC_W'(TOTAL_WORDS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(LED_NUM - 1);

   state_t            state_q, state_d;
   logic [4:0]        bit_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [31:0]       shreg;
   logic [4:0]        bright_q;
   logic [23:0]       pix_reg;
   logic              sk_ck_next, fall_tick, bit_end;
   logic              word_end, accept, refresh_end;
   logic [31:0]       next_word;

   sk9822_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (busy),
      .sk_ck_next (sk_ck_next),
      .fall_tick  (fall_tick),
      .bit_end    (bit_end)
   );

   assign word_end = bit_end && (bit_cnt == 5'd31);
   assign sk_da    = shreg[31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      refresh_end = 1'b0;
      case (state_q)
         IDLE:    if (start) begin
                     accept  = 1'b1;
                     state_d = START_F;
                  end
         START_F: if (word_end) state_d = PIXEL;
         PIXEL:   if (word_end && (word_cnt == LAST_PIX_IDX)) state_d = END_F;
         END_F:   if (word_end && (word_cnt == LAST_WORD_IDX)) begin
                     state_d     = IDLE;
                     refresh_end = 1'b1;
                  end
         default: state_d = IDLE;
      endcase
      next_word = (state_d == PIXEL)
                ? {HDR, bright_q, pix_reg[7:0], pix_reg[15:8], pix_reg[23:16]}
                : END_WORD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         sk_ck    <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         bright_q <= '0;
         pix_addr <= '0;
         pix_reg  <= '0;
      end else begin
         done    <= 1'b0;
         sk_ck   <= sk_ck_next;
         pix_reg <= pix_data;
         if (accept) begin
            busy     <= 1'b1;
            bright_q <= bright;
            pix_addr <= '0;
            word_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= START_WORD;
         end else if (refresh_end) begin
            // shreg is left as is: its MSB is the final end-frame '1', so sk_da idles high.
            busy <= 1'b0;
            done <= 1'b1;
         end else if (word_end) begin
            word_cnt <= word_cnt + WC_W'(1);
            bit_cnt  <= '0;
            shreg    <= next_word;
         end else if (bit_end) begin
            bit_cnt  <= bit_cnt + 5'd1;
            shreg    <= {shreg[30:0], 1'b0};
         end
         // Fetch the next pixel as soon as the current pixel word has been loaded.
         if (fall_tick && (bit_cnt == '0) && (state_q == PIXEL) && (pix_addr != LAST_ADDR))
            pix_addr <= pix_addr + ADDR_W'(1);
      end
   end

endmodule

// File: doc/sk9822_chain_driver.md
Name: sk9822_chain_driver

Overview:
- Parametrised SK9822/APA102 chain driver. Streams one full refresh to a chain of LED_NUM LEDs per start request.
- Per-LED colour is fetched from an external pixel store through a synchronous read port; global brightness comes from a port.
- Sits between a pixel buffer/pattern engine and the two LED pins. Adds start/busy/done handshaking and a chain-length-scaled end frame.

Parameters:
- LED_NUM, 11: LEDs in chain, range 1..(2**ADDR_W).
- CLK_DIV, 14: clk cycles per SCK half-period, minimum 2. At 27 MHz the default gives ~964 kHz SCK.
- ADDR_W, 8: pixel address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request for one refresh
- bright  in  5  global brightness, latched on accepted start
- pix_addr  out  ADDR_W  pixel index being fetched
- pix_data  in  24  {R[7:0],G[7:0],B[7:0]}, valid 1 clk after pix_addr
- busy  out  1  refresh in progress
- done  out  1  one-cycle pulse at refresh end
- sk_ck  out  1  LED clock
- sk_da  out  1  LED data

Behaviour:
- Reset is asynchronous and active-low. Reset values: sk_ck=0, sk_da=0, busy=0, done=0, pix_addr=0, state IDLE, all counters 0.
- Reset asserted mid-refresh aborts immediately, with no partial end frame. The next refresh begins with a full start frame so the chain resyncs.
- States:
  - IDLE -> START_F when start=1.
  - START_F: 1 word, 0x00000000.
  - PIXEL: LED_NUM words.
  - END_F: END_WORDS words of 0xFFFFFFFF, where END_WORDS = (LED_NUM+63)/64, integer division, minimum 1. This gives at least LED_NUM/2 trailing clocks.
  - END_F -> IDLE.
- Start acceptance: start is accepted only in IDLE; start while busy=1 is ignored.
  - On the accepted cycle, bright is latched, pix_addr is set to 0 and the word counter is cleared.
  - busy rises on the next clk.
- Bit timing, MSB first, one bit = 2*CLK_DIV clk cycles:
  - Low phase: sk_ck=0 for CLK_DIV cycles. sk_da is updated at the first cycle of the low phase.
  - High phase: sk_ck=1 for CLK_DIV cycles. The LED samples on the rising edge.
- Pixel word: {3'b111, bright_latched, B, G, R}, sent in that order.
- Words are held in a 32-bit shift register. Each word is loaded at its bit-0 low phase.
- Pixel fetch:
  - pix_addr for pixel k is driven no later than the high phase of the last bit of the preceding word.
  - pix_data is registered one clk later, which is guaranteed before the load since CLK_DIV>=2.
  - pix_addr increments once per pixel word and holds its last value during END_F.
- Refresh end:
  - After the high phase of the final END_F bit, sk_ck returns to 0 and sk_da holds 1.
  - done pulses for 1 clk and busy falls in the same cycle. Next state is IDLE.
- Duration: busy is high for exactly 32*(1+LED_NUM+END_WORDS)*2*CLK_DIV clk cycles.
  - Default: 416 bits, 11648 cycles.
- start on the done cycle is accepted (state is IDLE). A back-to-back refresh follows with no gap beyond 1 clk.
- Counter widths:
  - Bit counter: 5 bits, wraps 31->0 at each word boundary.
  - Word counter: sized for LED_NUM+1+END_WORDS.
  - Divider counter: sized for CLK_DIV-1.
- bright changes while busy have no effect until the next accepted start.

Decomposition:
- Package sk9822_pkg:
  - START_WORD=32'h00000000, END_WORD=32'hFFFFFFFF, HDR=3'b111.
  - State enum {IDLE, START_F, PIXEL, END_F}.
  - Function end_words(led_num).
- Sub-module sk9822_sck_gen, parameter CLK_DIV: divider plus phase toggle.
  - Outputs sk_ck_next, fall_tick (start of low phase) and bit_end (end of high phase).
  - Enable input tied to busy. Its counter clears when disabled.

Test Plan:
- Default params, memory model pix[k]={8'd(k), 8'h80, 8'h01}, bright=5'b01111. Pulse start, then decode on sk_ck rising:
  - First word 0x00000000.
  - Word for LED 3 = 0xEF018003 ({111,01111,B=01,G=80,R=03}).
  - 11 pixel words, then 1 word 0xFFFFFFFF.
  - done after 11648 clk. busy high for exactly that span.
- LED_NUM=1, CLK_DIV=2: 96 bits, SCK period 4 clk. Assert pix_addr=0 throughout. done at cycle 384.
- LED_NUM=70: 2 end words (64 ones). Last pix_addr=69.
- Assert start again at cycles 100 and 5000 of a refresh: both ignored. Change bright mid-refresh: all pixel words carry the old brightness. start on the done cycle: second refresh begins the following clk.
- Drop rst_n at cycle 3000: all outputs 0 asynchronously. Release and start: decoded stream again begins with 32 zeros and matches the full expected refresh.
